// File: rtl/mvb_frame_gen.sv
// rtl/mvb_frame_gen.sv - MVB test-frame generator with period, timeout and optional loopback checker
//
// Purpose: fills the Encode transmit FIFO with a selectable pattern, launches the
// frame on M_frame/S_frame with a send_frame strobe, waits for frame_over (or a
// timeout) and repeats every PERIOD clk cycles while enable is high.
// Optional feature: define MVB_GEN_CHECK_EN to build the loopback checker that
// compares decoder words (rx_valid/rx_data) against the regenerated pattern.
//
// Ports:
//   clk           system clock (24 MHz)
//   rst           asynchronous active-low reset
//   enable        run generator, sampled in IDLE and at frame end
//   frame_length  words per frame (0 -> 1, clamped to MAX_WORDS)
//   mode          0 increment, 1 constant SEED, 2 LFSR, 3 walking one
//   master        1 = M_frame, 0 = S_frame, latched at frame start
//   frame_over    completion from Encode (level or pulse)
//   fifo_write_en one-clk FIFO write strobe
//   data_out      write data, valid with fifo_write_en
//   M_frame       master frame type, FILL through WAIT_OVER
//   S_frame       slave frame type, FILL through WAIT_OVER
//   send_frame    launch strobe, SEND_HOLD cycles
//   busy          high in any state but IDLE
//   frame_count   completed frames, wrapping
//   timeout_err   sticky completion timeout flag
//   rx_valid      decoder word valid (checker)
//   rx_data       decoder word (checker)
//   chk_errors    saturating count of mismatching decoder words
module mvb_frame_gen #(
  parameter int          MAX_WORDS = 16,
  parameter int          PERIOD    = 25000,
  parameter int          WORD_DIV  = 8,
  parameter int          SEND_HOLD = 31,
  parameter int          TIMEOUT   = 65535,
  parameter logic [15:0] SEED      = 16'h7EC3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [6:0]  frame_length,
  input  logic [1:0]  mode,
  input  logic        master,
  input  logic        frame_over,
  output logic        fifo_write_en,
  output logic [15:0] data_out,
  output logic        M_frame,
  output logic        S_frame,
  output logic        send_frame,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        timeout_err,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  output logic [15:0] chk_errors
);

  // One phase counter serves the word divider, the send hold and the timeout.
  localparam int CMAX = (TIMEOUT > SEND_HOLD) ?
                        ((TIMEOUT > WORD_DIV) ? TIMEOUT : WORD_DIV) :
                        ((SEND_HOLD > WORD_DIV) ? SEND_HOLD : WORD_DIV);
  localparam int CW = $clog2(CMAX + 1);
  localparam int PW = $clog2(PERIOD + 1);

  typedef enum logic [2:0] {IDLE, WAIT_PERIOD, FILL, SEND, WAIT_OVER} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   period_cnt;
  logic [6:0]      len_q, word_cnt, len_clamped;
  logic [1:0]      mode_q;
  logic            master_q;
  logic [15:0]     cur_word;
  logic [3:0]      word_idx;
  logic            in_frame, period_done, over_done, timed_out, fill_entry;

  // Successor of a pattern word; idx is the index of the word being produced,
  // used only by the walking-one pattern.
  function automatic logic [15:0] pattern_next(input logic [1:0] m,
                                               input logic [15:0] cur,
                                               input logic [3:0] idx);
    logic [15:0] lfsr;
    lfsr = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    case (m)
      2'd0:    pattern_next = cur + 16'd1;
      2'd1:    pattern_next = SEED;
      2'd2:    pattern_next = (lfsr == 16'd0) ? SEED : lfsr;
      default: pattern_next = 16'd1 << idx;
    endcase
  endfunction

  always_comb begin
    len_clamped = frame_length;
    if (frame_length == 7'd0)
      len_clamped = 7'd1;
    else if (frame_length > 7'(MAX_WORDS))
      len_clamped = 7'(MAX_WORDS);
  end

  assign period_done = (period_cnt == PW'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state    = state;
    fifo_write_en = 1'b0;
    send_frame    = 1'b0;
    busy          = 1'b1;
    in_frame      = 1'b0;
    over_done     = 1'b0;
    timed_out     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (enable) next_state = FILL;
      end
      WAIT_PERIOD: begin
        if (period_done) next_state = enable ? FILL : IDLE;
      end
      FILL: begin
        in_frame = 1'b1;
        if (cnt == '0) begin
          fifo_write_en = 1'b1;
          if (word_cnt == len_q - 7'd1) next_state = SEND;
        end
      end
      SEND: begin
        in_frame   = 1'b1;
        send_frame = 1'b1;
        if (cnt == CW'(SEND_HOLD - 1)) next_state = WAIT_OVER;
      end
      WAIT_OVER: begin
        in_frame = 1'b1;
        // A completion in the timeout cycle wins over the timeout.
        if (frame_over)                    over_done = 1'b1;
        else if (cnt == CW'(TIMEOUT - 1))  timed_out = 1'b1;
        // A frame that overran its period restarts straight away.
        if (over_done || timed_out)
          next_state = period_done ? (enable ? FILL : IDLE) : WAIT_PERIOD;
      end
      default: next_state = IDLE;
    endcase
  end

  assign fill_entry = (next_state == FILL) && (state != FILL);
  assign data_out   = fifo_write_en ? cur_word : 16'd0;
  assign M_frame    = in_frame & master_q;
  assign S_frame    = in_frame & ~master_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      period_cnt  <= '0;
      len_q       <= 7'd0;
      word_cnt    <= 7'd0;
      mode_q      <= 2'd0;
      master_q    <= 1'b0;
      cur_word    <= 16'd0;
      word_idx    <= 4'd0;
      frame_count <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      if (next_state != state)
        cnt <= '0;
      else if (state == FILL && cnt == CW'(WORD_DIV - 1))
        cnt <= '0;
      else if (state == FILL || state == SEND || state == WAIT_OVER)
        cnt <= cnt + CW'(1);

      if (fill_entry) begin
        mode_q     <= mode;
        master_q   <= master;
        len_q      <= len_clamped;
        word_cnt   <= 7'd0;
        cur_word   <= SEED;
        word_idx   <= 4'd0;
        period_cnt <= '0;
      end else begin
        if (fifo_write_en) begin
          word_cnt <= word_cnt + 7'd1;
          word_idx <= word_idx + 4'd1;
          cur_word <= pattern_next(mode_q, cur_word, word_idx + 4'd1);
        end
        if (state == IDLE)
          period_cnt <= '0;
        else if (!period_done)
          period_cnt <= period_cnt + PW'(1);
      end

      if (over_done) frame_count <= frame_count + 16'd1;
      if (timed_out) timeout_err <= 1'b1;
    end
  end

`ifdef MVB_GEN_CHECK_EN
  logic [15:0] chk_word;
  logic [3:0]  chk_idx;
  logic [15:0] err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_word <= 16'd0;
      chk_idx  <= 4'd0;
      err_cnt  <= 16'd0;
    end else if (fill_entry) begin
      chk_word <= SEED;
      chk_idx  <= 4'd0;
    end else if (rx_valid) begin
      if (rx_data != chk_word && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
      chk_word <= pattern_next(mode_q, chk_word, chk_idx + 4'd1);
      chk_idx  <= chk_idx + 4'd1;
    end
  end

  assign chk_errors = err_cnt;
`else
  logic unused_rx;
  assign unused_rx  = ^{rx_valid, rx_data};
  assign chk_errors = 16'd0;
`endif

endmodule

// File: doc/mvb_frame_gen.md
# mvb_frame_gen

Parametrised MVB test-frame generator for the single 24 MHz domain. It fills the Encode transmit FIFO with a selectable data pattern, launches the frame on the S/M frame-type lines and waits for completion, repeating at a programmable period. It replaces hand-built derived-clock stimulus with clock-enable timing, and adds frame counting, a completion timeout and an optional loopback checker against the decoder output.

## Interface
- MAX_WORDS, 16: maximum words per frame; frame_length above this is clamped.
- PERIOD, 25000: clk cycles from one frame start to the next frame start.
- WORD_DIV, 8: clk cycles between FIFO writes.
- SEND_HOLD, 31: clk cycles send_frame stays high.
- TIMEOUT, 65535: clk cycles allowed in WAIT_OVER.
- SEED, 16'h7EC3: first data word of every frame.

Ports:
- clk  in  1  system clock (24 MHz).
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run generator; sampled in IDLE and at frame end.
- frame_length  in  7  words per frame; 0 treated as 1.
- mode  in  2  pattern: 0 increment, 1 constant SEED, 2 LFSR, 3 walking one.
- master  in  1  1 = M_frame, 0 = S_frame; latched at frame start.
- frame_over  in  1  completion from Encode, level or pulse.
- fifo_write_en  out  1  one-clk write strobe.
- data_out  out  16  write data, valid with fifo_write_en.
- M_frame, S_frame  out  1  frame type, held from FILL through WAIT_OVER.
- send_frame  out  1  launch strobe.
- busy  out  1  high in any state but IDLE.
- frame_count  out  16  completed frames, wraps at 16'hFFFF to 0.
- timeout_err  out  1  sticky; cleared only by reset.
- rx_valid  in  1  decoder word valid (checker).
- rx_data  in  16  decoder word (checker).
- chk_errors  out  16  mismatching words, saturating.

## Operation
- States: IDLE, WAIT_PERIOD, FILL, SEND, WAIT_OVER.
- IDLE: enable=1 -> FILL; period counter cleared.
- FILL:
  - Latch mode, master and clamped length L.
  - Write L words, one per WORD_DIV cycles; the first write is on the first FILL cycle.
  - After the L-th write -> SEND.
- Patterns:
  - Word 0 is always SEED.
  - Increment: +1 mod 2^16.
  - Constant: SEED.
  - LFSR: Fibonacci x^16+x^14+x^13+x^11+1 shifting left; feedback into bit 0. A zero state is replaced by SEED.
  - Walking one: 16'h0001 rotated left once per word, after word 0.
- SEND: send_frame high SEND_HOLD cycles -> WAIT_OVER.
- WAIT_OVER:
  - frame_over high: frame_count+1 -> WAIT_PERIOD.
  - Counter reaches TIMEOUT first: set timeout_err -> WAIT_PERIOD; no count.
- WAIT_PERIOD:
  - Period counter, started at FILL entry, reaches PERIOD-1: enable=1 -> FILL, else -> IDLE.
  - If the frame took at least PERIOD cycles, the next frame starts the cycle after WAIT_OVER exits.
- enable dropping mid-frame: the current frame completes, then IDLE.
- Reset values: every output 0, state IDLE, all counters 0.

## Timing
- fifo_write_en: exactly one cycle wide, WORD_DIV cycles apart. Write k occurs on FILL cycle k*WORD_DIV.
- send_frame rises on the cycle after the last write cycle.
- M_frame/S_frame are valid from the first FILL cycle and drop on WAIT_OVER exit.
- frame_over is sampled only in WAIT_OVER; frame_over and a timeout in the same cycle count as completion.
- Asynchronous reset mid-frame: outputs clear immediately, with no partial-frame send.

## Configuration
- MVB_GEN_CHECK_EN defined:
  - A checker regenerates the pattern from SEED with the latched mode.
  - Each rx_valid word is compared in order; a mismatch increments chk_errors.
  - The expected pointer rewinds at every FILL entry.
- Undefined: rx_valid and rx_data are ignored; chk_errors is tied to 0.

## Test plan
- Reset, enable=1, frame_length=16, mode=0, PERIOD=2000 -> 16 strobes, data 7EC3..7ED2, 8 cycles apart. send_frame high 31 cycles. frame_over after 100 cycles -> frame_count=1; next FILL 2000 cycles after the first.
- mode=2, frame_length=4 -> data 7EC3 then 3 LFSR successors per the polynomial; mode=3 -> 7EC3, 0002, 0004, 0008.
- frame_length=0 -> 1 write; frame_length=100 -> 16 writes.
- frame_over held low, TIMEOUT=500 -> timeout_err=1 after 500 cycles in WAIT_OVER; frame_count unchanged; next frame still starts.
- enable dropped during FILL -> frame finishes, busy=0 afterwards; rst low mid-SEND -> all outputs 0 within the same cycle.
- With MVB_GEN_CHECK_EN: loop the data back with word 3 corrupted -> chk_errors=1; clean loopback -> 0.
